// File: rtl/reg_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package reg_wb_pkg;

   localparam int REG_ADR_W  = 6;
   localparam int REG_DATA_W = 32;
   localparam int REG_NUM    = 32;

   localparam logic [REG_ADR_W-1:0] REG_PC_ADR   = 6'd32;
   localparam logic [REG_ADR_W-1:0] REG_ZERO_ADR = 6'd0;

   typedef struct packed {
      logic [REG_ADR_W-1:0]  adr;
      logic [REG_DATA_W-1:0] data;
   } wb_req_t;

   // 1..32 are real write targets.
   function automatic logic adr_legal(input logic [REG_ADR_W-1:0] a);
      return (a != REG_ZERO_ADR) && (a <= REG_PC_ADR);
   endfunction

   // 33..63 have no register behind them.
   function automatic logic adr_illegal(input logic [REG_ADR_W-1:0] a);
      return a > REG_PC_ADR;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback buffer: DEPTH-entry FIFO with sync clear.
// With REG_WB_PENDING_EN defined it also exposes its slots for pending tracking.
module wb_fifo
   import reg_wb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset_n,
   input  logic    clear,
   input  logic    push,
   input  wb_req_t push_req,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output wb_req_t head
`ifdef REG_WB_PENDING_EN
   ,
   output logic [DEPTH-1:0]    slot_vld,
   output wb_req_t [DEPTH-1:0] slot
`endif
);

   localparam int PW = $clog2(DEPTH);

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW:0]          wr_ptr, rd_ptr;
   wb_req_t [DEPTH-1:0]  mem;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign head  = mem[rd_ptr[PW-1:0]];

   // Pointer update; clear wins over any push/pop in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers qualify them.
   always_ff @(posedge clk) begin
      if (push && !full && !clear) mem[wr_ptr[PW-1:0]] <= push_req;
   end

`ifdef REG_WB_PENDING_EN
   logic [PW:0] count;
   assign count = wr_ptr - rd_ptr;
   assign slot  = mem;

   // A slot is live when its distance from the read pointer is below the fill level.
   always_comb begin
      slot_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot_vld[i] = {1'b0, PW'(PW'(i) - rd_ptr[PW-1:0])} < count;
      end
   end
`endif

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter between pipeline writeback (req0) and the
// multi-cycle unit (req1). req0 has priority; req1 is force-granted after
// MAX_WAIT denied cycles. Optional feature macro: REG_WB_PENDING_EN adds
// PENDING_MASK_SW for decode-stage hazard stalls.
module reg_wb_arbiter
   import reg_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  FLUSH_SD,
   input  logic                  REQ0_VALID_SW,
   input  logic [REG_ADR_W-1:0]  REQ0_ADR_SW,
   input  logic [REG_DATA_W-1:0] REQ0_DATA_SW,
   output logic                  REQ0_READY_SW,
   input  logic                  REQ1_VALID_SW,
   input  logic [REG_ADR_W-1:0]  REQ1_ADR_SW,
   input  logic [REG_DATA_W-1:0] REQ1_DATA_SW,
   output logic                  REQ1_READY_SW,
   output logic [REG_DATA_W-1:0] WDATA_SW,
   output logic [REG_ADR_W-1:0]  WADR_SW,
   output logic                  WENABLE_SW,
   output logic                  ILLEGAL_ADR_SW
`ifdef REG_WB_PENDING_EN
   ,
   output logic [REG_NUM:0]      PENDING_MASK_SW
`endif
);

   localparam int NUM_REQ = 2;
   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);

   logic    [NUM_REQ-1:0] valid, push, full, empty, grant;
   wb_req_t [NUM_REQ-1:0] in_req, head;
   wb_req_t               win;
   logic    [WAIT_W-1:0]  wait_cnt;
   logic                  starved;

`ifdef REG_WB_PENDING_EN
   logic    [NUM_REQ-1:0][FIFO_DEPTH-1:0] slot_vld;
   wb_req_t [NUM_REQ-1:0][FIFO_DEPTH-1:0] slot;
`endif

   assign valid     = {REQ1_VALID_SW, REQ0_VALID_SW};
   assign in_req[0] = {REQ0_ADR_SW, REQ0_DATA_SW};
   assign in_req[1] = {REQ1_ADR_SW, REQ1_DATA_SW};

   assign REQ0_READY_SW = !full[0];
   assign REQ1_READY_SW = !full[1];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      // Writes offered during a flush cycle are dropped, not buffered.
      assign push[g] = valid[g] && !full[g] && !FLUSH_SD;

      wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk      (clk),
         .reset_n  (reset_n),
         .clear    (FLUSH_SD),
         .push     (push[g]),
         .push_req (in_req[g]),
         .pop      (grant[g]),
         .full     (full[g]),
         .empty    (empty[g]),
         .head     (head[g])
`ifdef REG_WB_PENDING_EN
         ,
         .slot_vld (slot_vld[g]),
         .slot     (slot[g])
`endif
      );
   end

   assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

   // One winner per cycle: req0 unless req1 has waited MAX_WAIT cycles.
   always_comb begin
      grant = '0;
      if (!FLUSH_SD) begin
         if (!empty[0] && !empty[1]) grant = starved ? 2'b10 : 2'b01;
         else if (!empty[0])         grant = 2'b01;
         else if (!empty[1])         grant = 2'b10;
      end
   end

   assign win = grant[1] ? head[1] : head[0];

   // Count cycles req1 sits at the head without a grant, saturating at MAX_WAIT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                            wait_cnt <= '0;
      else if (FLUSH_SD || empty[1] || grant[1]) wait_cnt <= '0;
      else if (!starved)                       wait_cnt <= wait_cnt + 1'b1;
   end

   // Registered write port; address/data only change on a grant.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         WDATA_SW       <= '0;
         WADR_SW        <= '0;
         WENABLE_SW     <= 1'b0;
         ILLEGAL_ADR_SW <= 1'b0;
      end else if (|grant) begin
         WDATA_SW       <= win.data;
         WADR_SW        <= win.adr;
         WENABLE_SW     <= adr_legal(win.adr);
         ILLEGAL_ADR_SW <= adr_illegal(win.adr);
      end else begin
         WENABLE_SW     <= 1'b0;
         ILLEGAL_ADR_SW <= 1'b0;
      end
   end

`ifdef REG_WB_PENDING_EN
   // Any buffered or about-to-land write to r marks r busy; r0 never is.
   always_comb begin
      PENDING_MASK_SW = '0;
      for (int g = 0; g < NUM_REQ; g++) begin
         for (int s = 0; s < FIFO_DEPTH; s++) begin
            if (slot_vld[g][s] && adr_legal(slot[g][s].adr)) PENDING_MASK_SW[slot[g][s].adr] = 1'b1;
         end
      end
      if (WENABLE_SW) PENDING_MASK_SW[WADR_SW] = 1'b1;
   end
`endif

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a per-requester scoreboard.
module tb_reg_wb_arbiter;
   import reg_wb_pkg::*;

   localparam int MAX_WAIT = 4;

   logic        clk = 1'b0;
   logic        reset_n, FLUSH_SD;
   logic        v0, v1;
   logic [5:0]  a0, a1;
   logic [31:0] d0, d1;
   logic        REQ0_READY_SW, REQ1_READY_SW, WENABLE_SW, ILLEGAL_ADR_SW;
   logic [31:0] WDATA_SW;
   logic [5:0]  WADR_SW;
`ifdef REG_WB_PENDING_EN
   logic [32:0] PENDING_MASK_SW;
`endif

   always #5 clk = ~clk;

   reg_wb_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(MAX_WAIT)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .FLUSH_SD       (FLUSH_SD),
      .REQ0_VALID_SW  (v0),
      .REQ0_ADR_SW    (a0),
      .REQ0_DATA_SW   (d0),
      .REQ0_READY_SW  (REQ0_READY_SW),
      .REQ1_VALID_SW  (v1),
      .REQ1_ADR_SW    (a1),
      .REQ1_DATA_SW   (d1),
      .REQ1_READY_SW  (REQ1_READY_SW),
      .WDATA_SW       (WDATA_SW),
      .WADR_SW        (WADR_SW),
      .WENABLE_SW     (WENABLE_SW),
      .ILLEGAL_ADR_SW (ILLEGAL_ADR_SW)
`ifdef REG_WB_PENDING_EN
      ,
      .PENDING_MASK_SW(PENDING_MASK_SW)
`endif
   );

   typedef struct {
      logic [5:0]  adr;
      logic [31:0] data;
      logic        wen;
      logic        ill;
   } exp_t;

   exp_t    sb0[$], sb1[$];
   wb_req_t tx0[$], tx1[$];
   int n_tests = 0, n_fail = 0, cyc = 0, t9 = -1, n_wen = 0, n_ill = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input wb_req_t r);
      exp_t e;
      e.adr  = r.adr;
      e.data = r.data;
      e.wen  = (r.adr != 6'd0) && (r.adr <= 6'd32);
      e.ill  = (r.adr > 6'd32);
      return e;
   endfunction

   // One clock: drive heads of tx queues, record accepted writes, check outputs.
   task automatic tick();
      logic acc0, acc1, found;
      exp_t e;
      v0 = (tx0.size() > 0);
      v1 = (tx1.size() > 0);
      if (v0) begin a0 = tx0[0].adr; d0 = tx0[0].data; end
      if (v1) begin a1 = tx1[0].adr; d1 = tx1[0].data; end
      acc0 = v0 && REQ0_READY_SW && !FLUSH_SD;
      acc1 = v1 && REQ1_READY_SW && !FLUSH_SD;
      if (FLUSH_SD) begin sb0.delete(); sb1.delete(); end
      if (acc0 && tx0[0].adr != 6'd0) sb0.push_back(mk(tx0[0]));
      if (acc1 && tx1[0].adr != 6'd0) sb1.push_back(mk(tx1[0]));
      @(posedge clk);
      if (acc0) void'(tx0.pop_front());
      if (acc1) void'(tx1.pop_front());
      #1;
      cyc++;
      if (WENABLE_SW) n_wen++;
      if (ILLEGAL_ADR_SW) n_ill++;
      if (WENABLE_SW || ILLEGAL_ADR_SW) begin
         found = 1'b0;
         if (sb0.size() > 0 && sb0[0].adr == WADR_SW && sb0[0].data == WDATA_SW) begin
            e = sb0.pop_front(); found = 1'b1;
         end else if (sb1.size() > 0 && sb1[0].adr == WADR_SW && sb1[0].data == WDATA_SW) begin
            e = sb1.pop_front(); found = 1'b1;
         end
         check("sb_match", {found, WADR_SW, WDATA_SW}, {1'b1, WADR_SW, WDATA_SW});
         if (found) check("sb_flags", {WENABLE_SW, ILLEGAL_ADR_SW}, {e.wen, e.ill});
         if (WENABLE_SW && WADR_SW == 6'd9) t9 = cyc;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) tick();
      check("sb_empty", sb0.size() + sb1.size(), 0);
   endtask

   initial begin
      int t_acc, k, wen_mark, ill_mark;
      logic seen;
      reset_n = 1'b0; FLUSH_SD = 1'b0;
      v0 = 1'b0; v1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
      #12;
      check("rst_ready", {REQ0_READY_SW, REQ1_READY_SW}, 2'b11);
      check("rst_wport", {WENABLE_SW, ILLEGAL_ADR_SW, WADR_SW, WDATA_SW}, '0);
      @(negedge clk) reset_n = 1'b1;

      // Idle
      repeat (10) tick();
      check("idle_wen", n_wen, 0);
      check("idle_ill", n_ill, 0);
      check("idle_ready", {REQ0_READY_SW, REQ1_READY_SW}, 2'b11);

      // Single write, two-cycle latency, one-cycle enable
      tx0.push_back('{adr: 6'd5, data: 32'hDEADBEEF});
      tick();
      check("single_early", WENABLE_SW, 1'b0);
      tick();
      check("single_write", {WENABLE_SW, WADR_SW, WDATA_SW}, {1'b1, 6'd5, 32'hDEADBEEF});
      tick();
      check("single_once", WENABLE_SW, 1'b0);
      drain(3);

      // req1 starvation bound under a continuous req0 stream
      for (int i = 1; i <= 8; i++) tx0.push_back('{adr: 6'(i), data: 32'h3000_0000 + i});
      tx1.push_back('{adr: 6'd9, data: 32'h0000_9999});
      tick();
      t_acc = cyc;
      check("starve_acc", tx1.size(), 0);
      repeat (15) tick();
      check("starve_lat", t9 - t_acc, MAX_WAIT + 1);
      drain(4);

      // req1 FIFO full while req0 streams; READY returns with the first req1 grant
      for (int i = 11; i <= 20; i++) tx0.push_back('{adr: 6'(i), data: 32'h4000_0000 + i});
      tx1.push_back('{adr: 6'd21, data: 32'h5000_0021});
      tx1.push_back('{adr: 6'd22, data: 32'h5000_0022});
      tick();
      tick();
      check("full_ready_lo", REQ1_READY_SW, 1'b0);
      seen = 1'b0; k = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         tick();
         if (WENABLE_SW && WADR_SW == 6'd21) begin
            seen = 1'b1; k = i;
            check("full_ready_hi", REQ1_READY_SW, 1'b1);
         end else begin
            check("full_ready_hold", REQ1_READY_SW, 1'b0);
         end
      end
      check("full_grant_cyc", k, MAX_WAIT);
      drain(25);

      // Address 0 dropped silently, address 40 flagged
      wen_mark = n_wen; ill_mark = n_ill;
      tx0.push_back('{adr: 6'd0,  data: 32'hAAAA_0000});
      tx0.push_back('{adr: 6'd40, data: 32'hBBBB_0040});
      drain(6);
      check("adr_wen", n_wen - wen_mark, 0);
      check("adr_ill", n_ill - ill_mark, 1);

      // Flush with buffered entries and valids active
      for (int i = 23; i <= 25; i++) tx1.push_back('{adr: 6'(i), data: 32'h6000_0000 + i});
      for (int i = 1; i <= 8; i++) tx0.push_back('{adr: 6'(i), data: 32'h7000_0000 + i});
      repeat (3) tick();
      FLUSH_SD = 1'b1;
      tick();
      FLUSH_SD = 1'b0;
      tx0.delete(); tx1.delete();
      check("flush_wen", WENABLE_SW, 1'b0);
      check("flush_ready", {REQ0_READY_SW, REQ1_READY_SW}, 2'b11);
      check("flush_wait", dut.wait_cnt, 0);
`ifdef REG_WB_PENDING_EN
      check("flush_mask", PENDING_MASK_SW, '0);
`endif
      wen_mark = n_wen;
      drain(8);
      check("flush_nowr", n_wen - wen_mark, 0);

      // Asynchronous reset in the middle of traffic
      for (int i = 1; i <= 3; i++) tx0.push_back('{adr: 6'(i), data: 32'h8000_0000 + i});
      tick();
      tick();
      #2 reset_n = 1'b0;
      #1;
      check("arst_wport", {WENABLE_SW, WADR_SW, WDATA_SW}, '0);
      check("arst_ready", {REQ0_READY_SW, REQ1_READY_SW}, 2'b11);
      tx0.delete(); sb0.delete(); sb1.delete();
      v0 = 1'b0;
      @(negedge clk) reset_n = 1'b1;
      wen_mark = n_wen;
      drain(4);
      check("arst_nowr", n_wen - wen_mark, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
